bsg_manycore_link_sram_responder: RTL

- Endpoint on the far (south) side of a manycore cache link; used as a behavioural stand-in for a victim cache and bound to one cache_link_sif pair plus its x/y coordinate.
- Accepts remote load and store request packets on the forward network and performs each one on a local word-addressed SRAM.
- Returns exactly one response packet per request on the reverse network, in order.

---
 rtl/bsg_manycore_link_sram_responder.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_link_sram_responder.sv
// Far-side manycore link endpoint: serves remote loads/stores from a local word SRAM
// and returns one in-order response per request (credit for stores, int_wb for loads).
module bsg_manycore_link_sram_responder #(
    parameter int addr_width_p    = 16,
    parameter int data_width_p    = 32,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 4,
    parameter int load_id_width_p = 5,
    parameter int mem_els_p       = 1024,
    parameter int max_out_p       = 2,
    localparam int mask_width_lp  = data_width_p / 8,
    localparam int cord_width_lp  = 2 * (x_cord_width_p + y_cord_width_p),
    localparam int fwd_pkt_width_lp = addr_width_p + 2 + mask_width_lp + load_id_width_p
                                      + data_width_p + cord_width_lp,
    localparam int ret_pkt_width_lp = 2 + data_width_p + load_id_width_p + cord_width_lp,
    localparam int link_sif_width_lp = fwd_pkt_width_lp + ret_pkt_width_lp + 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    input  logic [x_cord_width_p-1:0]    my_x_i,
    input  logic [y_cord_width_p-1:0]    my_y_i
);

    localparam int idx_width_lp = $clog2(mem_els_p);
    localparam int cnt_width_lp = $clog2(max_out_p + 1);
    localparam int ptr_width_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;

    typedef enum logic [1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1
    } op_e;

    typedef enum logic [1:0] {
        e_return_credit = 2'd0,
        e_return_int_wb = 2'd1
    } ret_type_e;

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic [1:0]                 op;
        logic [mask_width_lp-1:0]   mask;
        logic [load_id_width_p-1:0] load_id;
        logic [data_width_p-1:0]    payload;
        logic [y_cord_width_p-1:0]  src_y_cord;
        logic [x_cord_width_p-1:0]  src_x_cord;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } fwd_pkt_s;

    typedef struct packed {
        logic [1:0]                 pkt_type;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  src_y_cord;
        logic [x_cord_width_p-1:0]  src_x_cord;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } ret_pkt_s;

    typedef struct packed {
        logic     v;
        fwd_pkt_s data;
        logic     ready_and_rev;
    } fwd_ch_s;

    typedef struct packed {
        logic     v;
        ret_pkt_s data;
        logic     ready_and_rev;
    } rev_ch_s;

    typedef struct packed {
        fwd_ch_s fwd;
        rev_ch_s rev;
    } link_sif_s;

    link_sif_s w_link_in;
    link_sif_s w_link_out;
    fwd_pkt_s  w_req;
    logic      w_unused;

    assign w_link_in  = link_sif_i;
    assign link_sif_o = w_link_out;
    assign w_req      = w_link_in.fwd.data;
    // Outgoing-forward ready, reverse-in v/data and the upper address bits are not needed here.
    assign w_unused   = ^w_link_in;

    logic                     r_live;
    logic [cnt_width_lp-1:0]  r_out_cnt;
    logic                     w_fwd_ready;
    logic                     w_accept;
    logic                     w_is_store;
    logic                     w_op_known;
    logic [idx_width_lp-1:0]  w_idx;
    logic                     w_ret_v;
    logic                     w_ret_ready;
    logic                     w_pop;

    assign w_fwd_ready = r_live && (r_out_cnt < cnt_width_lp'(max_out_p));
    assign w_accept    = w_link_in.fwd.v && w_fwd_ready;
    assign w_is_store  = (w_req.op == e_remote_store);
    assign w_op_known  = (w_req.op == e_remote_load) || (w_req.op == e_remote_store);
    assign w_idx       = w_req.addr[idx_width_lp-1:0];
    assign w_ret_ready = w_link_in.rev.ready_and_rev;
    assign w_pop       = w_ret_v && w_ret_ready;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_live    <= 1'b0;
            r_out_cnt <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept && !w_pop) begin
                r_out_cnt <= r_out_cnt + cnt_width_lp'(1);
            end else if (!w_accept && w_pop) begin
                r_out_cnt <= r_out_cnt - cnt_width_lp'(1);
            end
        end
    end

    logic [data_width_p-1:0] r_mem [mem_els_p];
    logic [data_width_p-1:0] r_rdata;

    // NOTE: SRAM and FIFO storage are deliberately not reset; only valid/pointer state is.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            if (w_is_store) begin
                for (int b = 0; b < mask_width_lp; b++) begin
                    if (w_req.mask[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_req.payload[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    logic                       r_s1_v;
    logic                       r_s1_is_load;
    logic [load_id_width_p-1:0] r_s1_load_id;
    logic [x_cord_width_p-1:0]  r_s1_src_x;
    logic [y_cord_width_p-1:0]  r_s1_src_y;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s1_v       <= 1'b0;
            r_s1_is_load <= 1'b0;
            r_s1_load_id <= '0;
            r_s1_src_x   <= '0;
            r_s1_src_y   <= '0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_is_load <= !w_is_store;
                r_s1_load_id <= w_req.load_id;
                r_s1_src_x   <= w_req.src_x_cord;
                r_s1_src_y   <= w_req.src_y_cord;
            end
        end
    end

    ret_pkt_s w_s1_pkt;

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        w_s1_pkt            = '0;
        w_s1_pkt.pkt_type   = r_s1_is_load ? e_return_int_wb : e_return_credit;
        w_s1_pkt.data       = r_s1_is_load ? r_rdata : '0;
        w_s1_pkt.load_id    = r_s1_load_id;
        w_s1_pkt.src_x_cord = my_x_i;
        w_s1_pkt.src_y_cord = my_y_i;
        w_s1_pkt.x_cord     = r_s1_src_x;
        w_s1_pkt.y_cord     = r_s1_src_y;
    end

    ret_pkt_s                r_fifo_mem [max_out_p];
    logic [ptr_width_lp-1:0] r_wr_ptr;
    logic [ptr_width_lp-1:0] r_rd_ptr;
    logic [cnt_width_lp-1:0] r_fifo_cnt;
    logic                    w_fifo_empty;
    logic                    w_enq;
    logic                    w_deq;
    ret_pkt_s                w_ret_pkt;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_out_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // An empty FIFO lets the stage-1 response fall straight through, giving 1-cycle latency.
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_ret_v      = !w_fifo_empty || r_s1_v;
    assign w_ret_pkt    = w_fifo_empty ? w_s1_pkt : r_fifo_mem[r_rd_ptr];
    assign w_deq        = !w_fifo_empty && w_ret_ready;
    assign w_enq        = r_s1_v && !(w_fifo_empty && w_ret_ready);

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo_mem[r_wr_ptr] <= w_s1_pkt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_enq && !w_deq) begin
                r_fifo_cnt <= r_fifo_cnt + cnt_width_lp'(1);
            end else if (!w_enq && w_deq) begin
                r_fifo_cnt <= r_fifo_cnt - cnt_width_lp'(1);
            end
        end
    end

    always_comb begin
        w_link_out                   = '0;
        w_link_out.fwd.ready_and_rev = w_fwd_ready;
        w_link_out.rev.v             = w_ret_v;
        w_link_out.rev.data          = w_ret_pkt;
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            assert (w_op_known)
            else $error("sram_responder: unsupported op %0d, handled as a load", w_req.op);
        end
        if (w_enq && !w_deq) begin
            assert (r_fifo_cnt < cnt_width_lp'(max_out_p))
            else $error("sram_responder: response FIFO overflow");
        end
    end

endmodule
